// File: rtl/tow_push_arbiter_if.sv
// Player/start inputs and scoreboard outputs of the tug-of-war controller.
interface tow_push_arbiter_if #(
  parameter int POS_W = 4
) ();
  logic                    push_l;
  logic                    push_r;
  logic                    start;
  logic signed [POS_W-1:0] pos;
  logic                    win_l;
  logic                    win_r;
  logic                    acc_l;
  logic                    acc_r;
  logic [1:0]              state;

  modport master (
    output push_l, push_r, start,
    input  pos, win_l, win_r, acc_l, acc_r, state
  );

  modport slave (
    input  push_l, push_r, start,
    output pos, win_l, win_r, acc_l, acc_r, state
  );
endinterface

// File: rtl/tow_push_arbiter.sv
// Tug-of-war round sequencer: edge detect, false-start check, press arbitration
// with per-player cooldown, signed rope position and winner latch.
//
// state | meaning
// IDLE  | waiting for start, rope centred, no winner
// ARMED | countdown running, any push edge is a false start
// PLAY  | presses move the rope until one side reaches WIN_DIST
// DONE  | result frozen until the next start
module tow_push_arbiter #(
  parameter int POS_W     = 4,
  parameter int WIN_DIST  = 5,
  parameter int START_DLY = 8,
  parameter int LOCKOUT   = 2
) (
  input logic               clk,
  input logic               rst,
  tow_push_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    PLAY  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic signed [POS_W-1:0] WIN_POS   = POS_W'(WIN_DIST);
  localparam logic signed [POS_W-1:0] WIN_NEG   = -WIN_POS;
  localparam logic signed [POS_W-1:0] ONE       = POS_W'(1);
  localparam logic [7:0]              ARM_LOAD  = 8'(START_DLY - 1);
  localparam logic [7:0]              COOL_LOAD = 8'(LOCKOUT);

  state_t                  state_q, state_nxt;
  logic signed [POS_W-1:0] pos_q, pos_nxt, pos_step;
  logic                    win_l_q, win_l_nxt, win_r_q, win_r_nxt;
  logic                    acc_l_q, acc_l_nxt, acc_r_q, acc_r_nxt;
  logic [7:0]              cnt_q, cnt_nxt;
  logic [7:0]              cool_l_q, cool_l_nxt, cool_r_q, cool_r_nxt;
  logic                    push_l_dly, push_r_dly, start_dly;
  logic                    e_l, e_r, e_start, elig_l, elig_r;

  assign e_l     = bus.push_l & ~push_l_dly;
  assign e_r     = bus.push_r & ~push_r_dly;
  assign e_start = bus.start  & ~start_dly;
  assign elig_l  = e_l && (cool_l_q == 8'd0);
  assign elig_r  = e_r && (cool_r_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      win_l_q    <= 1'b0;
      win_r_q    <= 1'b0;
      acc_l_q    <= 1'b0;
      acc_r_q    <= 1'b0;
      cnt_q      <= 8'd0;
      cool_l_q   <= 8'd0;
      cool_r_q   <= 8'd0;
      push_l_dly <= 1'b0;
      push_r_dly <= 1'b0;
      start_dly  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pos_q      <= pos_nxt;
      win_l_q    <= win_l_nxt;
      win_r_q    <= win_r_nxt;
      acc_l_q    <= acc_l_nxt;
      acc_r_q    <= acc_r_nxt;
      cnt_q      <= cnt_nxt;
      cool_l_q   <= cool_l_nxt;
      cool_r_q   <= cool_r_nxt;
      push_l_dly <= bus.push_l;
      push_r_dly <= bus.push_r;
      start_dly  <= bus.start;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    pos_nxt    = pos_q;
    win_l_nxt  = win_l_q;
    win_r_nxt  = win_r_q;
    acc_l_nxt  = 1'b0;
    acc_r_nxt  = 1'b0;
    cnt_nxt    = cnt_q;
    cool_l_nxt = (cool_l_q != 8'd0) ? cool_l_q - 8'd1 : 8'd0;
    cool_r_nxt = (cool_r_q != 8'd0) ? cool_r_q - 8'd1 : 8'd0;
    pos_step   = pos_q;

    case (state_q)
      IDLE: begin
        pos_nxt   = '0;
        win_l_nxt = 1'b0;
        win_r_nxt = 1'b0;
        if (e_start) begin
          state_nxt = ARMED;
          cnt_nxt   = ARM_LOAD;
        end
      end

      ARMED: begin
        // A foul on the terminal-count cycle still beats the transition to PLAY.
        if (e_l && e_r) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (e_l) begin
          state_nxt = DONE;
          win_r_nxt = 1'b1;
          cnt_nxt   = 8'd0;
        end else if (e_r) begin
          state_nxt = DONE;
          win_l_nxt = 1'b1;
          cnt_nxt   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_nxt = PLAY;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end

      PLAY: begin
        if (elig_l) begin
          acc_l_nxt  = 1'b1;
          cool_l_nxt = COOL_LOAD;
        end
        if (elig_r) begin
          acc_r_nxt  = 1'b1;
          cool_r_nxt = COOL_LOAD;
        end
        if (elig_l && !elig_r)      pos_step = pos_q - ONE;
        else if (elig_r && !elig_l) pos_step = pos_q + ONE;
        pos_nxt = pos_step;
        if (pos_step == WIN_NEG) begin
          win_l_nxt = 1'b1;
          state_nxt = DONE;
        end else if (pos_step == WIN_POS) begin
          win_r_nxt = 1'b1;
          state_nxt = DONE;
        end
      end

      DONE: begin
        cool_l_nxt = 8'd0;
        cool_r_nxt = 8'd0;
        if (e_start) begin
          state_nxt = IDLE;
          pos_nxt   = '0;
          win_l_nxt = 1'b0;
          win_r_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.state = state_q;
  assign bus.pos   = pos_q;
  assign bus.win_l = win_l_q;
  assign bus.win_r = win_r_q;
  assign bus.acc_l = acc_l_q;
  assign bus.acc_r = acc_r_q;
endmodule

// File: tb/tb_tow_push_arbiter.sv
// Bench for tow_push_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and random play against a timestamp-based round model.
module tb_tow_push_arbiter;
  localparam int POS_W     = 4;
  localparam int WIN_DIST  = 5;
  localparam int START_DLY = 8;
  localparam int LOCKOUT   = 2;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_PLAY  = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tow_push_arbiter_if #(.POS_W(POS_W)) bus ();

  tow_push_arbiter #(
    .POS_W(POS_W), .WIN_DIST(WIN_DIST), .START_DLY(START_DLY), .LOCKOUT(LOCKOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Round model: phases as plain integers, countdown and cooldown as timestamps.
  int m_phase = P_IDLE, m_pos = 0;
  int m_wl = 0, m_wr = 0, m_al = 0, m_ar = 0;
  int cyc = 0, arm_at = 0, last_l = -1000, last_r = -1000;
  int pl_prev = 0, pr_prev = 0, st_prev = 0;

  typedef struct {
    logic rs, pl, pr, st;
    int   st_e, pos_e;
    int   wl_e, wr_e, al_e, ar_e;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic pl, logic pr, logic st,
                              int st_e, int pos_e, int wl_e, int wr_e);
    vec_t v;
    v.rs = rs; v.pl = pl; v.pr = pr; v.st = st;
    v.st_e = st_e; v.pos_e = pos_e; v.wl_e = wl_e; v.wr_e = wr_e;
    v.al_e = 0; v.ar_e = 0;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(int pl, int pr, int st, int rs);
    int el, er, es, okl, okr;
    cyc++;
    if (rs != 0) begin
      m_phase = P_IDLE; m_pos = 0; m_wl = 0; m_wr = 0; m_al = 0; m_ar = 0;
      pl_prev = 0; pr_prev = 0; st_prev = 0;
      return;
    end
    el = (pl != 0 && pl_prev == 0) ? 1 : 0;
    er = (pr != 0 && pr_prev == 0) ? 1 : 0;
    es = (st != 0 && st_prev == 0) ? 1 : 0;
    m_al = 0; m_ar = 0;
    case (m_phase)
      P_IDLE: begin
        m_pos = 0; m_wl = 0; m_wr = 0;
        if (es != 0) begin m_phase = P_ARMED; arm_at = cyc; end
      end
      P_ARMED: begin
        if (el != 0 && er != 0) m_phase = P_IDLE;
        else if (el != 0) begin m_phase = P_DONE; m_wr = 1; end
        else if (er != 0) begin m_phase = P_DONE; m_wl = 1; end
        else if (cyc - arm_at >= START_DLY) begin
          m_phase = P_PLAY; last_l = -1000; last_r = -1000;
        end
      end
      P_PLAY: begin
        okl = (el != 0 && cyc - last_l > LOCKOUT) ? 1 : 0;
        okr = (er != 0 && cyc - last_r > LOCKOUT) ? 1 : 0;
        if (okl != 0) begin m_al = 1; last_l = cyc; end
        if (okr != 0) begin m_ar = 1; last_r = cyc; end
        m_pos = m_pos + okr - okl;
        if (m_pos == -WIN_DIST) begin m_wl = 1; m_phase = P_DONE; end
        else if (m_pos == WIN_DIST) begin m_wr = 1; m_phase = P_DONE; end
      end
      default: begin
        if (es != 0) begin m_phase = P_IDLE; m_pos = 0; m_wl = 0; m_wr = 0; end
      end
    endcase
    pl_prev = pl; pr_prev = pr; st_prev = st;
  endtask

  task automatic tick(logic pl, logic pr, logic st, logic rs, bit use_model);
    bus.push_l = pl; bus.push_r = pr; bus.start = st; rst = rs;
    @(posedge clk);
    #1;
    model_step(int'(pl), int'(pr), int'(st), int'(rs));
    if (use_model) begin
      chk("state", int'(bus.state), m_phase);
      chk("pos", int'($signed(bus.pos)), m_pos);
      chk("win_l", int'(bus.win_l), m_wl);
      chk("win_r", int'(bus.win_r), m_wr);
      chk("acc_l", int'(bus.acc_l), m_al);
      chk("acc_r", int'(bus.acc_r), m_ar);
      chk("win_exclusive", int'(bus.win_l & bus.win_r), 0);
    end
  endtask

  task automatic idle_ticks(int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic cur_l, cur_r, st_r, rs_r;
    int   p_push;
    bus.push_l = 1'b0; bus.push_r = 1'b0; bus.start = 1'b0;

    // reset, idle ignore, false starts (right, both), foul on terminal count
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    for (int k = 0; k < START_DLY - 1; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].pl, tbl[i].pr, tbl[i].st, tbl[i].rs, 1'b0);
      chk("vec_state", int'(bus.state), tbl[i].st_e);
      chk("vec_pos", int'($signed(bus.pos)), tbl[i].pos_e);
      chk("vec_win_l", int'(bus.win_l), tbl[i].wl_e);
      chk("vec_win_r", int'(bus.win_r), tbl[i].wr_e);
      chk("vec_acc_l", int'(bus.acc_l), tbl[i].al_e);
      chk("vec_acc_r", int'(bus.acc_r), tbl[i].ar_e);
    end

    // normal left win, countdown boundary
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_ticks(START_DLY - 1);
    chk("armed_last_cycle", int'(bus.state), 1);
    idle_ticks(1);
    chk("play_entry", int'(bus.state), 2);
    for (int k = 1; k <= WIN_DIST; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("left_acc", int'(bus.acc_l), 1);
      chk("left_pos", int'($signed(bus.pos)), -k);
      idle_ticks(3);
    end
    chk("left_win", int'(bus.win_l), 1);
    chk("left_done", int'(bus.state), 3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_ticks(1);
    chk("done_pos_hold", int'($signed(bus.pos)), -WIN_DIST);

    // restart: DONE -> IDLE -> ARMED -> PLAY
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("restart_idle", int'(bus.state), 0);
    chk("restart_win_clr", int'(bus.win_l), 0);
    idle_ticks(1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("restart_armed", int'(bus.state), 1);
    idle_ticks(START_DLY);
    chk("restart_play", int'(bus.state), 2);

    // cooldown: edge at +2 dropped, fresh edge at +3 accepted
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cool_first", int'($signed(bus.pos)), 1);
    idle_ticks(1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cool_drop_acc", int'(bus.acc_r), 0);
    chk("cool_drop_pos", int'($signed(bus.pos)), 1);
    idle_ticks(2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cool_second", int'($signed(bus.pos)), 2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_ticks(1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cool_expiry_acc", int'(bus.acc_r), 1);
    chk("cool_expiry_pos", int'($signed(bus.pos)), 3);
    idle_ticks(3);

    // simultaneous press, then both cooldowns active
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sim_pos", int'($signed(bus.pos)), 3);
    chk("sim_acc_l", int'(bus.acc_l), 1);
    chk("sim_acc_r", int'(bus.acc_r), 1);
    idle_ticks(1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sim_cool_l", int'(bus.acc_l), 0);
    chk("sim_cool_r", int'(bus.acc_r), 0);
    idle_ticks(3);

    // drive to -3 then reset mid-round
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_ticks(3);
    end
    chk("pre_reset_pos", int'($signed(bus.pos)), -3);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_reset_state", int'(bus.state), 0);
    chk("mid_reset_pos", int'($signed(bus.pos)), 0);
    idle_ticks(1);

    // random play against the model
    cur_l = 1'b0; cur_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      p_push = (m_phase == P_ARMED) ? 60 : 4;
      if ($urandom_range(p_push - 1) == 0) cur_l = ~cur_l;
      if ($urandom_range(p_push - 1) == 0) cur_r = ~cur_r;
      if (m_phase == P_IDLE || m_phase == P_DONE) st_r = ($urandom_range(7) == 0);
      else st_r = ($urandom_range(39) == 0);
      rs_r = ($urandom_range(699) == 0);
      tick(cur_l, cur_r, st_r, rs_r, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
